// File: rtl/bsg_fpu_pkg.sv
// Shared FPU definitions: normalizer FSM states, exponent bias helper and
// the unpacked operand layout used between FPU stages.
package bsg_fpu_pkg;

   typedef enum logic [1:0] {eIdle, eShift, eDone} bsg_fpu_norm_state_e;

   localparam int fpu_e_p_default = 5;
   localparam int fpu_m_p_default = 10;

   // exp is two's complement so normalized subnormals can go below zero
   typedef struct packed {
      logic                       sign;
      logic [fpu_e_p_default+1:0] exp;
      logic [fpu_m_p_default:0]   man;
   } bsg_fpu_unpacked_s;

   function automatic int bsg_fpu_bias(input int e_p);
      return (1 << (e_p - 1)) - 1;
   endfunction

endpackage

// File: rtl/bsg_fpu_preprocess.sv
// Splits a raw IEEE-754 operand into fields and classifies it.
module bsg_fpu_preprocess
  import bsg_fpu_pkg::*;
 #(parameter int e_p = 5
  ,parameter int m_p = 10)
  (input  logic [e_p+m_p:0] a_i
  ,output logic             sign_o
  ,output logic [e_p-1:0]   exp_o
  ,output logic [m_p-1:0]   man_o
  ,output logic             zero_o
  ,output logic             nan_o
  ,output logic             sig_nan_o
  ,output logic             infty_o
  ,output logic             denormal_o);

   logic exp_zero, exp_ones, man_zero;

   assign sign_o = a_i[e_p+m_p];
   assign exp_o  = a_i[e_p+m_p-1:m_p];
   assign man_o  = a_i[m_p-1:0];

   assign exp_zero = ~|exp_o;
   assign exp_ones = &exp_o;
   assign man_zero = ~|man_o;

   assign zero_o     = exp_zero & man_zero;
   assign denormal_o = exp_zero & ~man_zero;
   assign infty_o    = exp_ones & man_zero;
   assign nan_o      = exp_ones & ~man_zero;
   // quiet bit is the mantissa MSB; a NaN with it clear is signalling
   assign sig_nan_o  = nan_o & ~man_o[m_p-1];

endmodule

// File: rtl/bsg_fpu_normalize_denormal.sv
// Unpacks one operand per transaction; subnormals are normalized by a
// one-bit-per-cycle left shift so downstream stages see a hidden bit.
module bsg_fpu_normalize_denormal
  import bsg_fpu_pkg::*;
 #(parameter int e_p = 5
  ,parameter int m_p = 10)
  (input  logic             clk_i
  ,input  logic             reset_i
  ,input  logic             v_i
  ,input  logic [e_p+m_p:0] a_i
  ,output logic             ready_o
  ,output logic             v_o
  ,input  logic             yumi_i
  ,output logic             sign_o
  ,output logic [e_p+1:0]   exp_o
  ,output logic [m_p:0]     man_o
  ,output logic             zero_o
  ,output logic             nan_o
  ,output logic             sig_nan_o
  ,output logic             infty_o
  ,output logic             denormal_o);

   bsg_fpu_norm_state_e state_r, state_n;
   logic           sign_r, sign_n;
   logic [e_p+1:0] exp_r, exp_n;
   logic [m_p:0]   man_r, man_n;
   logic [4:0]     flags_r, flags_n;

   logic           pp_sign, pp_zero, pp_nan, pp_sig_nan, pp_infty, pp_denormal;
   logic [e_p-1:0] pp_exp;
   logic [m_p-1:0] pp_man;

   bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) pre
     (.a_i       (a_i)
     ,.sign_o    (pp_sign)
     ,.exp_o     (pp_exp)
     ,.man_o     (pp_man)
     ,.zero_o    (pp_zero)
     ,.nan_o     (pp_nan)
     ,.sig_nan_o (pp_sig_nan)
     ,.infty_o   (pp_infty)
     ,.denormal_o(pp_denormal));

   always_comb begin
      state_n = state_r;
      sign_n  = sign_r;
      exp_n   = exp_r;
      man_n   = man_r;
      flags_n = flags_r;
      unique case (state_r)
         eIdle: if (v_i) begin
            sign_n  = pp_sign;
            flags_n = {pp_zero, pp_nan, pp_sig_nan, pp_infty, pp_denormal};
            state_n = eDone;
            if (pp_zero) begin
               exp_n = '0;
               man_n = '0;
            end else if (pp_denormal) begin
               // a subnormal has the exponent of the smallest normal
               exp_n   = (e_p+2)'(1);
               man_n   = {1'b0, pp_man};
               state_n = eShift;
            end else if (pp_infty | pp_nan) begin
               exp_n = {2'b00, pp_exp};
               man_n = {1'b0, pp_man};
            end else begin
               exp_n = {2'b00, pp_exp};
               man_n = {1'b1, pp_man};
            end
         end
         eShift: if (man_r[m_p]) begin
            state_n = eDone;
         end else begin
            man_n = man_r << 1;
            exp_n = exp_r - (e_p+2)'(1);
         end
         eDone: if (yumi_i) state_n = eIdle;
         default: state_n = eIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= eIdle;
         sign_r  <= 1'b0;
         exp_r   <= '0;
         man_r   <= '0;
         flags_r <= '0;
      end else begin
         state_r <= state_n;
         sign_r  <= sign_n;
         exp_r   <= exp_n;
         man_r   <= man_n;
         flags_r <= flags_n;
      end
   end

   assign ready_o = (state_r == eIdle);
   assign v_o     = (state_r == eDone);
   assign sign_o  = sign_r;
   assign exp_o   = exp_r;
   assign man_o   = man_r;
   assign {zero_o, nan_o, sig_nan_o, infty_o, denormal_o} = flags_r;

endmodule
